cdr_tx_framer: RTL

- Serial transmitter that generates the NRZ bit stream consumed by the CDR/PFD loop. It emits one bit per refclk.
- Sequence after enable: an alternating training preamble for loop lock, then a sync word, then continuous 2-bit-header framed slots carrying user words or PRBS7 fill.
- Fill slots guarantee transition density, so the recovered clock never starves.
- Sits in top_dut, driven by refclk, with sdata feeding the phase detector data input.

---
 rtl/cdr_tx_framer.sv | 103 ++++++++++
 1 files changed

// File: rtl/cdr_tx_framer.sv
// cdr_tx_framer: NRZ serial transmitter emitting a training preamble, a sync word, then
// 2-bit-header framed slots carrying user words or PRBS7 fill for CDR lock.
module cdr_tx_framer #(
  parameter int WIDTH = 8,
  parameter int TRAIN_BITS = 64,
  parameter logic [WIDTH-1:0] SYNC_WORD = 'h47
) (
  input  logic             i_refclk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic             o_sdata,
  output logic             o_frame_start,
  output logic             o_locked_phase
);
  localparam int CW = $clog2(TRAIN_BITS + WIDTH + 2);
  typedef enum logic [1:0] {IDLE, TRAIN, SYNC, DATA} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [6:0]       r_lfsr;
  logic             r_is_data, r_sdata, r_fs;
  logic             w_last, w_accept;
  assign w_last = (r_state == SYNC && r_cnt == CW'(WIDTH - 1)) ||
                  (r_state == DATA && r_cnt == CW'(WIDTH + 1));
  assign o_tx_ready = w_last && i_enable;
  assign w_accept = o_tx_ready && i_tx_valid;
  assign o_sdata = r_sdata;
  assign o_frame_start = r_fs;
  assign o_locked_phase = r_state == SYNC || r_state == DATA;
  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_lfsr    <= 7'h7F;
      r_is_data <= 1'b0;
      r_sdata   <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      // every sync/slot end decides the next slot kind, or stops
      if (w_last) begin
        r_cnt <= '0;
        if (w_accept) begin
          r_state   <= DATA;
          r_shift   <= i_tx_data;
          r_is_data <= 1'b1;
          r_sdata   <= 1'b1;
          r_fs      <= 1'b1;
        end else if (i_enable) begin
          r_state   <= DATA;
          r_is_data <= 1'b0;
          r_sdata   <= 1'b0;
          r_fs      <= 1'b1;
        end else begin
          r_state <= IDLE;
          r_sdata <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_sdata <= i_enable;
            if (i_enable) r_state <= TRAIN;
          end
          TRAIN: begin
            if (r_cnt == CW'(TRAIN_BITS - 1)) begin
              r_cnt   <= '0;
              r_state <= i_enable ? SYNC : IDLE;
              r_sdata <= i_enable && SYNC_WORD[WIDTH-1];
              r_fs    <= i_enable;
              r_shift <= SYNC_WORD << 1;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_sdata <= ~r_sdata;
            end
          end
          SYNC: begin
            r_cnt   <= r_cnt + CW'(1);
            r_sdata <= r_shift[WIDTH-1];
            r_shift <= r_shift << 1;
          end
          default: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == '0) begin
              r_sdata <= ~r_is_data;
            end else if (r_is_data) begin
              r_sdata <= r_shift[WIDTH-1];
              r_shift <= r_shift << 1;
            end else begin
              // PRBS7 x^7+x^6+1, stepped only on fill payload bits
              r_sdata <= r_lfsr[6];
              r_lfsr  <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            end
          end
        endcase
      end
    end
  end
endmodule
